// File: rtl/mc_axi_src_mux_pkg.sv
// Shared AXI4 channel types for the memory-controller source mux, plus the
// widened-ID variants used on the merged memory-controller side.
package mc_axi_src_mux_pkg;

  localparam int unsigned MC_AXI_ADDR_BW        = 32;
  localparam int unsigned MC_AXI_DATA_BW        = 32;
  localparam int unsigned MC_AXI_STRB_BW        = MC_AXI_DATA_BW / 8;
  localparam int unsigned MC_AXI_AW_ID_BW       = 8;
  localparam int unsigned MC_AXI_AR_ID_BW       = 8;
  localparam int unsigned MC_AXI_SRC_IDX_BW_MAX = 3;
  localparam int unsigned MC_AXI_MUX_AW_ID_BW   = MC_AXI_AW_ID_BW + MC_AXI_SRC_IDX_BW_MAX;
  localparam int unsigned MC_AXI_MUX_AR_ID_BW   = MC_AXI_AR_ID_BW + MC_AXI_SRC_IDX_BW_MAX;

  function automatic int unsigned log2ceil(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  typedef struct packed {
    logic                         awvalid;
    logic [MC_AXI_AW_ID_BW-1:0]   awid;
    logic [MC_AXI_ADDR_BW-1:0]    awaddr;
    logic [7:0]                   awlen;
    logic [2:0]                   awsize;
    logic [1:0]                   awburst;
    logic                         wvalid;
    logic [MC_AXI_DATA_BW-1:0]    wdata;
    logic [MC_AXI_STRB_BW-1:0]    wstrb;
    logic                         wlast;
    logic                         bready;
    logic                         arvalid;
    logic [MC_AXI_AR_ID_BW-1:0]   arid;
    logic [MC_AXI_ADDR_BW-1:0]    araddr;
    logic [7:0]                   arlen;
    logic [2:0]                   arsize;
    logic [1:0]                   arburst;
    logic                         rready;
  } t_to_mc_axi4;

  typedef struct packed {
    logic                         awready;
    logic                         wready;
    logic                         bvalid;
    logic [MC_AXI_AW_ID_BW-1:0]   bid;
    logic [1:0]                   bresp;
    logic                         arready;
    logic                         rvalid;
    logic [MC_AXI_AR_ID_BW-1:0]   rid;
    logic [MC_AXI_DATA_BW-1:0]    rdata;
    logic [1:0]                   rresp;
    logic                         rlast;
  } t_from_mc_axi4;

  typedef struct packed {
    logic                           awvalid;
    logic [MC_AXI_MUX_AW_ID_BW-1:0] awid;
    logic [MC_AXI_ADDR_BW-1:0]      awaddr;
    logic [7:0]                     awlen;
    logic [2:0]                     awsize;
    logic [1:0]                     awburst;
    logic                           wvalid;
    logic [MC_AXI_DATA_BW-1:0]      wdata;
    logic [MC_AXI_STRB_BW-1:0]      wstrb;
    logic                           wlast;
    logic                           bready;
    logic                           arvalid;
    logic [MC_AXI_MUX_AR_ID_BW-1:0] arid;
    logic [MC_AXI_ADDR_BW-1:0]      araddr;
    logic [7:0]                     arlen;
    logic [2:0]                     arsize;
    logic [1:0]                     arburst;
    logic                           rready;
  } t_to_mc_axi4_mux;

  typedef struct packed {
    logic                           awready;
    logic                           wready;
    logic                           bvalid;
    logic [MC_AXI_MUX_AW_ID_BW-1:0] bid;
    logic [1:0]                     bresp;
    logic                           arready;
    logic                           rvalid;
    logic [MC_AXI_MUX_AR_ID_BW-1:0] rid;
    logic [MC_AXI_DATA_BW-1:0]      rdata;
    logic [1:0]                     rresp;
    logic                           rlast;
  } t_from_mc_axi4_mux;

endpackage

// File: rtl/mc_rr_arb.sv
// Round-robin arbiter with a grant lock: while hold is high the current grant
// is kept; the pointer moves past the winner only when a grant is released.
module mc_rr_arb
  import mc_axi_src_mux_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               hold,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned PTR_BW = log2ceil(NUM_REQ);

  logic [PTR_BW-1:0]  ptr_q, ptr_d;
  logic               lock_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] rr_gnt;

  always_comb begin
    logic [PTR_BW-1:0] idx;
    idx    = '0;
    rr_gnt = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_BW'((32'(ptr_q) + k) % NUM_REQ);
      if (rr_gnt == '0 && req[idx]) rr_gnt[idx] = 1'b1;
    end
  end

  // A lock only survives while the locked requester is still asking.
  assign gnt = (lock_q && |(gnt_q & req)) ? gnt_q : rr_gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt && !hold) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (gnt[k]) ptr_d = PTR_BW'((k + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      lock_q <= 1'b0;
      gnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      lock_q <= hold & |gnt;
      gnt_q  <= gnt;
    end
  end

endmodule

// File: rtl/mc_axi_src_mux.sv
// Merges NUM_SRC AXI4 requestors onto one memory-controller port: AR/AW are
// round-robin arbitrated, W follows AW order via a small index FIFO, B/R route by ID.
module mc_axi_src_mux
  import mc_axi_src_mux_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned WQ_DEPTH = 4,
  parameter int unsigned SRC_BW   = log2ceil(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  t_to_mc_axi4       [NUM_SRC-1:0]   src_to_mc,
  output t_from_mc_axi4     [NUM_SRC-1:0]   src_from_mc,
  output t_to_mc_axi4_mux                   to_mc,
  input  t_from_mc_axi4_mux                 from_mc,
  output logic                              err_bad_id
);

  localparam int unsigned WQ_PTR_BW = log2ceil(WQ_DEPTH);

  logic                 run_q;
  logic [NUM_SRC-1:0]   ar_req, aw_req, ar_gnt, aw_gnt;
  logic                 ar_hold, aw_hold, aw_hs, w_hs;
  logic                 wq_push, wq_pop, wq_full, wq_empty;
  logic [SRC_BW-1:0]    wq_mem_q [WQ_DEPTH];
  logic [WQ_PTR_BW-1:0] wq_wr_q, wq_rd_q;
  logic [WQ_PTR_BW:0]   wq_cnt_q;
  logic [SRC_BW-1:0]    aw_idx, wq_head, b_idx, r_idx;
  logic                 b_bad, r_bad, err_q;
  logic                 unused_id;

  // run_q keeps every valid/ready low until the first edge after reset release.
  always_comb begin
    ar_req = '0;
    aw_req = '0;
    aw_idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      ar_req[i] = run_q & src_to_mc[i].arvalid;
      aw_req[i] = run_q & src_to_mc[i].awvalid;
      if (aw_gnt[i]) aw_idx = SRC_BW'(i);
    end
  end

  mc_rr_arb #(.NUM_REQ(NUM_SRC)) u_ar_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (ar_req),
    .hold    (ar_hold),
    .gnt     (ar_gnt)
  );

  mc_rr_arb #(.NUM_REQ(NUM_SRC)) u_aw_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (aw_req),
    .hold    (aw_hold),
    .gnt     (aw_gnt)
  );

  assign wq_full  = (wq_cnt_q == (WQ_PTR_BW + 1)'(WQ_DEPTH));
  assign wq_empty = (wq_cnt_q == '0);
  assign wq_head  = wq_mem_q[wq_rd_q];
  assign ar_hold  = |ar_gnt & ~from_mc.arready;
  assign aw_hs    = |aw_gnt & ~wq_full & from_mc.awready;
  assign aw_hold  = |aw_gnt & ~aw_hs;
  assign w_hs     = to_mc.wvalid & from_mc.wready;
  assign wq_push  = aw_hs;
  assign wq_pop   = w_hs & to_mc.wlast;

  assign b_idx     = from_mc.bid[MC_AXI_AW_ID_BW +: SRC_BW];
  assign r_idx     = from_mc.rid[MC_AXI_AR_ID_BW +: SRC_BW];
  assign b_bad     = 32'(b_idx) >= NUM_SRC;
  assign r_bad     = 32'(r_idx) >= NUM_SRC;
  assign unused_id = ^{from_mc.bid, from_mc.rid};
  assign err_bad_id = err_q;

  always_comb begin
    to_mc       = '0;
    src_from_mc = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (ar_gnt[i]) begin
        to_mc.arvalid                         = 1'b1;
        to_mc.arid[MC_AXI_AR_ID_BW-1:0]       = src_to_mc[i].arid;
        to_mc.arid[MC_AXI_AR_ID_BW +: SRC_BW] = SRC_BW'(i);
        to_mc.araddr                          = src_to_mc[i].araddr;
        to_mc.arlen                           = src_to_mc[i].arlen;
        to_mc.arsize                          = src_to_mc[i].arsize;
        to_mc.arburst                         = src_to_mc[i].arburst;
        src_from_mc[i].arready                = from_mc.arready;
      end
      if (aw_gnt[i]) begin
        to_mc.awvalid                         = ~wq_full;
        to_mc.awid[MC_AXI_AW_ID_BW-1:0]       = src_to_mc[i].awid;
        to_mc.awid[MC_AXI_AW_ID_BW +: SRC_BW] = SRC_BW'(i);
        to_mc.awaddr                          = src_to_mc[i].awaddr;
        to_mc.awlen                           = src_to_mc[i].awlen;
        to_mc.awsize                          = src_to_mc[i].awsize;
        to_mc.awburst                         = src_to_mc[i].awburst;
        src_from_mc[i].awready                = ~wq_full & from_mc.awready;
      end
      if (!wq_empty && wq_head == SRC_BW'(i)) begin
        to_mc.wvalid          = src_to_mc[i].wvalid;
        to_mc.wdata           = src_to_mc[i].wdata;
        to_mc.wstrb           = src_to_mc[i].wstrb;
        to_mc.wlast           = src_to_mc[i].wlast;
        src_from_mc[i].wready = from_mc.wready;
      end
      if (run_q && !b_bad && b_idx == SRC_BW'(i)) begin
        src_from_mc[i].bvalid = from_mc.bvalid;
        src_from_mc[i].bid    = from_mc.bid[MC_AXI_AW_ID_BW-1:0];
        src_from_mc[i].bresp  = from_mc.bresp;
        to_mc.bready          = src_to_mc[i].bready;
      end
      if (run_q && !r_bad && r_idx == SRC_BW'(i)) begin
        src_from_mc[i].rvalid = from_mc.rvalid;
        src_from_mc[i].rid    = from_mc.rid[MC_AXI_AR_ID_BW-1:0];
        src_from_mc[i].rdata  = from_mc.rdata;
        src_from_mc[i].rresp  = from_mc.rresp;
        src_from_mc[i].rlast  = from_mc.rlast;
        to_mc.rready          = src_to_mc[i].rready;
      end
    end
    // Responses for a nonexistent source are sunk so the MC never stalls.
    if (run_q && b_bad) to_mc.bready = 1'b1;
    if (run_q && r_bad) to_mc.rready = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      wq_wr_q  <= '0;
      wq_rd_q  <= '0;
      wq_cnt_q <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < WQ_DEPTH; i++) wq_mem_q[i] <= '0;
    end else begin
      run_q <= 1'b1;
      if (wq_push) begin
        wq_mem_q[wq_wr_q] <= aw_idx;
        wq_wr_q           <= wq_wr_q + WQ_PTR_BW'(1);
      end
      if (wq_pop) wq_rd_q <= wq_rd_q + WQ_PTR_BW'(1);
      case ({wq_push, wq_pop})
        2'b10:   wq_cnt_q <= wq_cnt_q + (WQ_PTR_BW + 1)'(1);
        2'b01:   wq_cnt_q <= wq_cnt_q - (WQ_PTR_BW + 1)'(1);
        default: wq_cnt_q <= wq_cnt_q;
      endcase
      err_q <= err_q | (run_q & ((from_mc.bvalid & b_bad) | (from_mc.rvalid & r_bad)));
    end
  end

endmodule

// File: tb/tb_mc_axi_src_mux.sv
// Bench for mc_axi_src_mux: directed scenarios plus a randomized AR run
// checked against a round-robin-with-lock reference model.
module tb_mc_axi_src_mux;
  import mc_axi_src_mux_pkg::*;

  localparam int unsigned NS = 3;
  localparam int unsigned WQ = 4;

  logic clk = 1'b0;
  logic reset_n;
  t_to_mc_axi4       [NS-1:0] src_to_mc;
  t_from_mc_axi4     [NS-1:0] src_from_mc;
  t_to_mc_axi4_mux            to_mc;
  t_from_mc_axi4_mux          from_mc;
  logic                       err_bad_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_axi_src_mux #(.NUM_SRC(NS), .WQ_DEPTH(WQ)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .src_to_mc   (src_to_mc),
    .src_from_mc (src_from_mc),
    .to_mc       (to_mc),
    .from_mc     (from_mc),
    .err_bad_id  (err_bad_id)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic do_reset();
    reset_n   = 1'b0;
    src_to_mc = '0;
    from_mc   = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    src_to_mc = '0;
    from_mc   = '0;
    src_to_mc[0].arvalid = 1'b1;
    src_to_mc[0].araddr  = 32'h0000_1000;
    src_to_mc[1].awvalid = 1'b1;
    src_to_mc[1].rready  = 1'b1;
    from_mc.rvalid  = 1'b1;
    from_mc.rid     = 11'h15A;
    from_mc.awready = 1'b1;
    from_mc.wready  = 1'b1;
    @(posedge clk); #2;
    total++; if (to_mc.arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b want=0", to_mc.arvalid); end
    total++; if (to_mc.awvalid !== 1'b0) begin bad++; $display("FAIL rst_awvalid got=%b want=0", to_mc.awvalid); end
    total++; if (to_mc.wvalid !== 1'b0) begin bad++; $display("FAIL rst_wvalid got=%b want=0", to_mc.wvalid); end
    total++; if (to_mc.rready !== 1'b0) begin bad++; $display("FAIL rst_rready got=%b want=0", to_mc.rready); end
    total++; if (src_from_mc[1].rvalid !== 1'b0) begin bad++; $display("FAIL rst_src_rvalid got=%b want=0", src_from_mc[1].rvalid); end
    total++; if (src_from_mc[1].awready !== 1'b0) begin bad++; $display("FAIL rst_awready got=%b want=0", src_from_mc[1].awready); end
    total++; if (err_bad_id !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_bad_id); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++; if (to_mc.arvalid !== 1'b0) begin bad++; $display("FAIL rel_noedge_arvalid got=%b want=0", to_mc.arvalid); end
    @(posedge clk); #1;
    total++; if (to_mc.arvalid !== 1'b1) begin bad++; $display("FAIL rel_arvalid got=%b want=1", to_mc.arvalid); end
    total++; if (to_mc.araddr !== 32'h0000_1000) begin bad++; $display("FAIL rel_araddr got=%h want=00001000", to_mc.araddr); end
    total++; if (to_mc.awvalid !== 1'b1) begin bad++; $display("FAIL rel_awvalid got=%b want=1", to_mc.awvalid); end
    total++; if (src_from_mc[1].rvalid !== 1'b1) begin bad++; $display("FAIL rel_rvalid got=%b want=1", src_from_mc[1].rvalid); end
  endtask

  task automatic test_ar_alternate();
    logic [10:0] exp_id;
    do_reset();
    src_to_mc[0].arvalid = 1'b1; src_to_mc[0].araddr = 32'hA000_0000; src_to_mc[0].arid = 8'h10;
    src_to_mc[1].arvalid = 1'b1; src_to_mc[1].araddr = 32'hA000_1111; src_to_mc[1].arid = 8'h21;
    from_mc.arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_id = (k % 2 == 0) ? 11'h010 : 11'h121;
      total++; if (to_mc.arid !== exp_id) begin bad++; $display("FAIL alt_arid[%0d] got=%h want=%h", k, to_mc.arid, exp_id); end
      total++; if (src_from_mc[k % 2].arready !== 1'b1 || src_from_mc[(k + 1) % 2].arready !== 1'b0) begin
        bad++; $display("FAIL alt_arready[%0d] got=%b%b want one-hot src%0d", k, src_from_mc[1].arready, src_from_mc[0].arready, k % 2);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ar_hold();
    do_reset();
    src_to_mc[1].arvalid = 1'b1; src_to_mc[1].araddr = 32'hB111_0000; src_to_mc[1].arid = 8'h33;
    from_mc.arready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        src_to_mc[0].arvalid = 1'b1; src_to_mc[0].araddr = 32'hB000_0000; src_to_mc[0].arid = 8'h44;
      end
      #1;
      total++; if (to_mc.araddr !== 32'hB111_0000) begin bad++; $display("FAIL hold_araddr[%0d] got=%h want=b1110000", k, to_mc.araddr); end
      @(posedge clk); #1;
    end
    from_mc.arready = 1'b1;
    #1;
    total++; if (to_mc.arid !== 11'h133) begin bad++; $display("FAIL hold_hs_arid got=%h want=133", to_mc.arid); end
    @(posedge clk); #1;
    src_to_mc[1].arvalid = 1'b0;
    #1;
    total++; if (to_mc.araddr !== 32'hB000_0000 || to_mc.arid !== 11'h044) begin
      bad++; $display("FAIL hold_next got=%h/%h want=b0000000/044", to_mc.araddr, to_mc.arid);
    end
  endtask

  task automatic test_w_order();
    do_reset();
    from_mc.awready = 1'b1;
    from_mc.wready  = 1'b1;
    src_to_mc[0].awvalid = 1'b1; src_to_mc[0].awid = 8'h11; src_to_mc[0].awlen = 8'd3;
    src_to_mc[0].awaddr  = 32'h0000_2000;
    src_to_mc[0].wvalid  = 1'b1; src_to_mc[0].wdata = 32'hD000_0000;
    #1;
    total++; if (to_mc.awvalid !== 1'b1 || to_mc.awid !== 11'h011) begin bad++; $display("FAIL word_aw0 got=%b/%h want=1/011", to_mc.awvalid, to_mc.awid); end
    total++; if (to_mc.wvalid !== 1'b0 || src_from_mc[0].wready !== 1'b0) begin
      bad++; $display("FAIL word_same_cycle_w got=%b/%b want=0/0", to_mc.wvalid, src_from_mc[0].wready);
    end
    @(posedge clk); #1;
    src_to_mc[0].awvalid = 1'b0;
    src_to_mc[1].awvalid = 1'b1; src_to_mc[1].awid = 8'h22; src_to_mc[1].awlen = 8'd0;
    src_to_mc[1].wvalid  = 1'b1; src_to_mc[1].wdata = 32'hB0B0_B0B0; src_to_mc[1].wlast = 1'b1;
    for (int b = 0; b < 4; b++) begin
      src_to_mc[0].wvalid = 1'b1;
      src_to_mc[0].wdata  = 32'hD000_0000 + 32'(b);
      src_to_mc[0].wlast  = (b == 3);
      #1;
      if (b == 0) begin
        total++; if (to_mc.awvalid !== 1'b1 || to_mc.awid !== 11'h122) begin bad++; $display("FAIL word_aw1 got=%b/%h want=1/122", to_mc.awvalid, to_mc.awid); end
      end
      total++; if (to_mc.wvalid !== 1'b1 || to_mc.wdata !== 32'hD000_0000 + 32'(b) || to_mc.wlast !== (b == 3)) begin
        bad++; $display("FAIL word_beat[%0d] got=%b/%h/%b want=1/%h/%b", b, to_mc.wvalid, to_mc.wdata, to_mc.wlast, 32'hD000_0000 + 32'(b), b == 3);
      end
      total++; if (src_from_mc[1].wready !== 1'b0 || src_from_mc[0].wready !== 1'b1) begin
        bad++; $display("FAIL word_wready[%0d] got=%b%b want=01", b, src_from_mc[1].wready, src_from_mc[0].wready);
      end
      @(posedge clk); #1;
      if (b == 0) src_to_mc[1].awvalid = 1'b0;
    end
    src_to_mc[0].wvalid = 1'b0;
    #1;
    total++; if (to_mc.wvalid !== 1'b1 || to_mc.wdata !== 32'hB0B0_B0B0 || src_from_mc[1].wready !== 1'b1) begin
      bad++; $display("FAIL word_src1 got=%b/%h/%b want=1/b0b0b0b0/1", to_mc.wvalid, to_mc.wdata, src_from_mc[1].wready);
    end
    @(posedge clk); #1;
    src_to_mc[1].wvalid = 1'b0;
    src_to_mc[0].wvalid = 1'b1;
    #1;
    total++; if (to_mc.wvalid !== 1'b0 || src_from_mc[0].wready !== 1'b0) begin
      bad++; $display("FAIL word_empty got=%b/%b want=0/0", to_mc.wvalid, src_from_mc[0].wready);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    from_mc.awready = 1'b1;
    from_mc.wready  = 1'b0;
    src_to_mc[0].awvalid = 1'b1; src_to_mc[0].awlen = 8'd0;
    for (int n = 0; n < 4; n++) begin
      src_to_mc[0].awid = 8'(n);
      #1;
      total++; if (to_mc.awvalid !== 1'b1) begin bad++; $display("FAIL full_aw[%0d] got=%b want=1", n, to_mc.awvalid); end
      @(posedge clk); #1;
    end
    src_to_mc[0].awid = 8'd4;
    #1;
    total++; if (to_mc.awvalid !== 1'b0 || src_from_mc[0].awready !== 1'b0) begin
      bad++; $display("FAIL full_aw5 got=%b/%b want=0/0", to_mc.awvalid, src_from_mc[0].awready);
    end
    src_to_mc[0].wvalid = 1'b1; src_to_mc[0].wlast = 1'b1; src_to_mc[0].wdata = 32'h5555_0000;
    from_mc.wready = 1'b1;
    #1;
    total++; if (to_mc.wvalid !== 1'b1 || to_mc.awvalid !== 1'b0) begin
      bad++; $display("FAIL full_pop_cycle got=%b/%b want=1/0", to_mc.wvalid, to_mc.awvalid);
    end
    @(posedge clk); #1;
    src_to_mc[0].wvalid = 1'b0;
    #1;
    total++; if (to_mc.awvalid !== 1'b1 || to_mc.awid !== 11'h004 || src_from_mc[0].awready !== 1'b1) begin
      bad++; $display("FAIL full_after_pop got=%b/%h/%b want=1/004/1", to_mc.awvalid, to_mc.awid, src_from_mc[0].awready);
    end
  endtask

  task automatic test_resp_route();
    do_reset();
    from_mc.rvalid = 1'b1; from_mc.rid = 11'h15A; from_mc.rdata = 32'hCAFE_F00D; from_mc.rlast = 1'b1;
    src_to_mc[0].rready = 1'b1;
    src_to_mc[1].rready = 1'b1;
    #1;
    total++; if (src_from_mc[1].rvalid !== 1'b1 || src_from_mc[1].rid !== 8'h5A || src_from_mc[1].rdata !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL route_r got=%b/%h/%h want=1/5a/cafef00d", src_from_mc[1].rvalid, src_from_mc[1].rid, src_from_mc[1].rdata);
    end
    total++; if (src_from_mc[0].rvalid !== 1'b0 || src_from_mc[2].rvalid !== 1'b0) begin
      bad++; $display("FAIL route_r_others got=%b%b want=00", src_from_mc[2].rvalid, src_from_mc[0].rvalid);
    end
    total++; if (to_mc.rready !== 1'b1) begin bad++; $display("FAIL route_rready1 got=%b want=1", to_mc.rready); end
    src_to_mc[1].rready = 1'b0;
    #1;
    total++; if (to_mc.rready !== 1'b0) begin bad++; $display("FAIL route_rready0 got=%b want=0", to_mc.rready); end
    from_mc.rvalid = 1'b0;
    from_mc.bvalid = 1'b1; from_mc.bid = 11'h2C3; from_mc.bresp = 2'b10;
    src_to_mc[2].bready = 1'b1;
    #1;
    total++; if (src_from_mc[2].bvalid !== 1'b1 || src_from_mc[2].bid !== 8'hC3 || src_from_mc[2].bresp !== 2'b10) begin
      bad++; $display("FAIL route_b got=%b/%h/%b want=1/c3/10", src_from_mc[2].bvalid, src_from_mc[2].bid, src_from_mc[2].bresp);
    end
    total++; if (to_mc.bready !== 1'b1 || src_from_mc[0].bvalid !== 1'b0) begin
      bad++; $display("FAIL route_bready got=%b/%b want=1/0", to_mc.bready, src_from_mc[0].bvalid);
    end
    @(posedge clk); #1;
    total++; if (err_bad_id !== 1'b0) begin bad++; $display("FAIL route_err got=%b want=0", err_bad_id); end
  endtask

  task automatic test_bad_id();
    do_reset();
    from_mc.rvalid = 1'b1; from_mc.rid = 11'h3A5;
    #1;
    total++; if (to_mc.rready !== 1'b1) begin bad++; $display("FAIL badid_rready got=%b want=1", to_mc.rready); end
    total++; if ((src_from_mc[0].rvalid | src_from_mc[1].rvalid | src_from_mc[2].rvalid) !== 1'b0) begin
      bad++; $display("FAIL badid_delivered got=%b%b%b want=000", src_from_mc[2].rvalid, src_from_mc[1].rvalid, src_from_mc[0].rvalid);
    end
    @(posedge clk); #1;
    from_mc.rvalid = 1'b0;
    #1;
    total++; if (err_bad_id !== 1'b1) begin bad++; $display("FAIL badid_err got=%b want=1", err_bad_id); end
    @(posedge clk); @(posedge clk); #1;
    total++; if (err_bad_id !== 1'b1) begin bad++; $display("FAIL badid_sticky got=%b want=1", err_bad_id); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    from_mc.awready = 1'b1;
    from_mc.wready  = 1'b1;
    src_to_mc[0].awvalid = 1'b1; src_to_mc[0].awlen = 8'd3; src_to_mc[0].awid = 8'h77;
    @(posedge clk); #1;
    src_to_mc[0].awvalid = 1'b0;
    src_to_mc[0].wvalid  = 1'b1; src_to_mc[0].wdata = 32'hE000_0000;
    #1;
    total++; if (to_mc.wvalid !== 1'b1) begin bad++; $display("FAIL mid_beat0 got=%b want=1", to_mc.wvalid); end
    @(posedge clk); #1;
    src_to_mc[0].wdata = 32'hE000_0001;
    reset_n = 1'b0;
    src_to_mc[0].arvalid = 1'b1;
    src_to_mc[1].awvalid = 1'b1;
    #1;
    total++; if ({to_mc.wvalid, to_mc.arvalid, to_mc.awvalid, src_from_mc[0].wready} !== 4'b0000) begin
      bad++; $display("FAIL mid_in_reset got=%b%b%b%b want=0000", to_mc.wvalid, to_mc.arvalid, to_mc.awvalid, src_from_mc[0].wready);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    src_to_mc[0].arvalid = 1'b0;
    src_to_mc[1].awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      total++; if (to_mc.wvalid !== 1'b0 || src_from_mc[0].wready !== 1'b0) begin
        bad++; $display("FAIL mid_stale[%0d] got=%b/%b want=0/0", k, to_mc.wvalid, src_from_mc[0].wready);
      end
    end
    src_to_mc[0].wvalid = 1'b0;
    src_to_mc[1].awvalid = 1'b1; src_to_mc[1].awlen = 8'd0; src_to_mc[1].awid = 8'h88;
    src_to_mc[1].wvalid  = 1'b1; src_to_mc[1].wdata = 32'hF000_0000; src_to_mc[1].wlast = 1'b1;
    #1;
    total++; if (to_mc.wvalid !== 1'b0) begin bad++; $display("FAIL mid_new_same got=%b want=0", to_mc.wvalid); end
    @(posedge clk); #1;
    src_to_mc[1].awvalid = 1'b0;
    #1;
    total++; if (to_mc.wvalid !== 1'b1 || to_mc.wdata !== 32'hF000_0000 || src_from_mc[1].wready !== 1'b1) begin
      bad++; $display("FAIL mid_new_beat got=%b/%h/%b want=1/f0000000/1", to_mc.wvalid, to_mc.wdata, src_from_mc[1].wready);
    end
  endtask

  // Sources keep arvalid until accepted; the model picks the locked source if any,
  // otherwise the first pending source at or after the pointer.
  task automatic test_ar_random();
    logic [NS-1:0] pend;
    logic [31:0]   addr [NS];
    logic [7:0]    id   [NS];
    logic [10:0]   exp_id;
    logic [NS-1:0] exp_rdy;
    int ptr, lock, g;
    do_reset();
    pend = '0;
    ptr  = 0;
    lock = -1;
    for (int i = 0; i < int'(NS); i++) begin addr[i] = '0; id[i] = '0; end
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < int'(NS); i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          addr[i] = $urandom;
          id[i]   = 8'($urandom);
        end
        src_to_mc[i].arvalid = pend[i];
        src_to_mc[i].araddr  = addr[i];
        src_to_mc[i].arid    = id[i];
      end
      from_mc.arready = 1'($urandom_range(0, 1));
      #1;
      g = -1;
      if (lock >= 0) g = lock;
      else for (int k = 0; k < int'(NS); k++) if (g < 0 && pend[(ptr + k) % NS]) g = (ptr + k) % NS;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = from_mc.arready;
      total++; if (to_mc.arvalid !== (g >= 0)) begin bad++; $display("FAIL rnd_arvalid[%0d] got=%b want=%b", c, to_mc.arvalid, g >= 0); end
      total++; if ({src_from_mc[2].arready, src_from_mc[1].arready, src_from_mc[0].arready} !== exp_rdy) begin
        bad++; $display("FAIL rnd_arready[%0d] got=%b%b%b want=%b", c, src_from_mc[2].arready, src_from_mc[1].arready, src_from_mc[0].arready, exp_rdy);
      end
      if (g >= 0) begin
        exp_id = (11'(g) << 8) | 11'(id[g]);
        total++; if (to_mc.araddr !== addr[g] || to_mc.arid !== exp_id) begin
          bad++; $display("FAIL rnd_ar[%0d] got=%h/%h want=%h/%h", c, to_mc.araddr, to_mc.arid, addr[g], exp_id);
        end
        if (from_mc.arready) begin
          pend[g] = 1'b0;
          ptr     = (g + 1) % NS;
          lock    = -1;
        end else begin
          lock = g;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    src_to_mc = '0;
    from_mc   = '0;
    test_reset();
    test_ar_alternate();
    test_ar_hold();
    test_w_order();
    test_fifo_full();
    test_resp_route();
    test_bad_id();
    test_reset_mid_burst();
    test_ar_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_axi_src_mux.md
MC_AXI_SRC_MUX -- requirements
Module: mc_axi_src_mux

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 2, meaning the number of AXI4 requestor ports; legal values are 2..8.
REQ-002 The block SHALL have parameter WQ_DEPTH, default 4, meaning the depth of the write-order FIFO; it is a power of two, at least 2.
REQ-003 The block SHALL have parameter SRC_BW = log2ceil(NUM_SRC), meaning the number of source-index bits carried in the upper ID field.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port src_to_mc, input, NUM_SRC x t_to_mc_axi4: the requests from each source.
REQ-007 The block SHALL have port src_from_mc, output, NUM_SRC x t_from_mc_axi4: the responses to each source.
REQ-008 The block SHALL have port to_mc, output, t_to_mc_axi4_mux: the merged request stream to the memory-controller channel.
REQ-009 The block SHALL have port from_mc, input, t_from_mc_axi4_mux: the responses from the memory-controller channel.

Function
REQ-010 AR and AW SHALL be arbitrated independently, each with its own round-robin pointer; after a grant, the granted index plus 1 becomes highest priority.
REQ-011 A grant SHALL be held while the selected valid is high and to_mc ready is low, so address and control stay stable per the AXI rules; re-arbitration happens only on the cycle after a handshake.
REQ-012 The forwarded arid/awid SHALL be formed as {zero pad, src_idx[SRC_BW-1:0], src_id[7:0]}; all other address and control fields SHALL pass through unmodified.
REQ-013 The address path SHALL be combinational pass-through with 0-cycle latency; only arbitration state is registered.
REQ-014 When an AW handshake occurs, the granted source index SHALL be pushed into the write-order FIFO.
REQ-015 AW SHALL be presented to the MC (awvalid=1) only when the FIFO is not full.
REQ-016 W beats SHALL be taken only from the source at the FIFO head; the FIFO pops on the handshake of the beat carrying wlast.
REQ-017 When the FIFO is empty, wvalid to the MC SHALL be 0 and all source wready SHALL be 0.
REQ-018 W data for a burst whose AW is handshaked in the same cycle SHALL be accepted no earlier than the next cycle.
REQ-019 A simultaneous push and pop SHALL leave the FIFO count unchanged; push while full SHALL be impossible by REQ-015.
REQ-020 FIFO pointers SHALL wrap modulo WQ_DEPTH.
REQ-021 B and R responses SHALL be routed by id[8 +: SRC_BW]; bid/rid delivered to the source are id[7:0].
REQ-022 MC bready/rready SHALL equal the addressed source's ready.
REQ-023 A response whose index is >= NUM_SRC SHALL be consumed (ready=1) and dropped, and SHALL set the sticky status bit err_bad_id.
REQ-024 awready, arready and wready SHALL be returned only to the granted or head source; all other sources see 0.
REQ-025 err_bad_id SHALL be an output of 1 bit, cleared only by reset.

Reset
REQ-026 While reset_n=0, all valid and ready outputs SHALL be 0, both round-robin pointers SHALL be 0, the grant locks SHALL be clear, the FIFO SHALL be empty, and err_bad_id SHALL be 0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; after deassertion no stale W beat is forwarded.
REQ-028 Outputs SHALL leave reset state on the first clk edge after deassertion, with no extra wait state.

Structure
REQ-029 The package SHALL add MC_AXI_SRC_IDX_BW_MAX=3, together with t_to_mc_axi4_mux and t_from_mc_axi4_mux whose ID fields are MC_AXI_*_ID_BW+3 bits wide.
REQ-030 log2ceil SHALL be reused from the package.
REQ-031 Round-robin arbitration SHALL be a sub-module, mc_rr_arb (NUM_SRC request, one-hot grant, hold input), instantiated twice.
REQ-032 The write-order FIFO SHALL be inline registers, not a vendor IP.

Verification
REQ-033 Src0 and src1 assert arvalid every cycle with arready=1 -> grants alternate 0,1,0,1; arid[8]=0 then 1.
REQ-034 Src1 holds arvalid, arready=0 for 3 cycles, and src0 raises arvalid in cycle 2 -> araddr stays src1's until the handshake.
REQ-035 AW src0 (awlen=3), then AW src1 (awlen=0); src1 presents W first -> only src0's 4 beats pass, then src1's beat; the FIFO returns to empty.
REQ-036 WQ_DEPTH=4, with 4 AWs accepted and no W -> 5th-AW awvalid to MC is 0; after one wlast, the 5th AW passes the next cycle.
REQ-037 MC returns rid={1,8'h5A} with NUM_SRC=2 -> src1 gets rid=8'h5A and rvalid=1; rid index 3 with NUM_SRC=3 -> dropped and err_bad_id=1.
REQ-038 reset_n is pulsed low in the 2nd beat of a 4-beat write -> all valids are 0 during reset, the FIFO is empty afterwards, and no W is forwarded until a new AW.
